// File: rtl/dnn_pkg.sv
// Shared NFU/eDRAM definitions: FSM encodings and default datapath sizes.
// Used by nbout_edram_writer (optional feature macro: NBOUT_WR_STICKY_ERR_EN).
package dnn_pkg;

  localparam int N_DEF  = 16;
  localparam int TN_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Pointer index width for a power-of-two FIFO; never below 1 bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/nbout_edram_writer_if.sv
// NFU-3 output stream in, eDRAM write port out. master = the writer block,
// slave = the surrounding NFU/eDRAM side.
interface nbout_edram_writer_if #(
  parameter int N        = 16,
  parameter int Tn       = 16,
  parameter int EDRAM_AW = 16
);
  logic                i_valid;
  logic [N*Tn-1:0]     i_data;
  logic                i_edram_ready;
  logic                o_edram_valid;
  logic [N*Tn-1:0]     o_edram_data;
  logic [EDRAM_AW-1:0] o_edram_addr;

  modport master (
    input  i_valid, i_data, i_edram_ready,
    output o_edram_valid, o_edram_data, o_edram_addr
  );

  modport slave (
    output i_valid, i_data, i_edram_ready,
    input  o_edram_valid, o_edram_data, o_edram_addr
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head: dout always holds the oldest entry
// whenever !empty, so a push into an empty FIFO is visible on the next cycle.
module sync_fifo
  import dnn_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = ptr_w(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, rd_ptr_n;
  logic         wr_en, rd_en;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count    = wr_ptr - rd_ptr;
  assign rd_en    = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en    = push && (!full || rd_en);
  assign rd_ptr_n = rd_ptr + (AW+1)'(rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_n;
      // Next head is either the word being written now or one already stored.
      if (wr_en && (rd_ptr_n == wr_ptr)) dout <= din;
      else if (rd_ptr_n != wr_ptr)       dout <= mem[rd_ptr_n[AW-1:0]];
    end
  end

endmodule

// File: rtl/nbout_edram_writer.sv
// Buffers NFU-3 output vectors and writes them to consecutive eDRAM lines.
// Define NBOUT_WR_STICKY_ERR_EN to add the sticky o_err drop flag.
module nbout_edram_writer
  import dnn_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int Tn       = TN_DEF,
  parameter int DEPTH    = 4,
  parameter int EDRAM_AW = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [EDRAM_AW-1:0] i_base_addr,
  input  logic [CNT_W-1:0]    i_num_beats,
  nbout_edram_writer_if.master bus,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_drop
`ifdef NBOUT_WR_STICKY_ERR_EN
  ,
  output logic                o_err
`endif
);

  localparam int CW = ptr_w(DEPTH) + 1;

  logic [1:0]          state, state_n;
  logic [CNT_W-1:0]    num_q, beat_cnt;
  logic [EDRAM_AW-1:0] addr_q;
  logic                fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic                start_ok, take, pop, last_beat;

  assign start_ok  = (state == ST_IDLE) && i_start;
  assign take      = (state == ST_RUN) && bus.i_valid;
  assign pop       = bus.o_edram_valid && bus.i_edram_ready;
  assign o_drop    = take && fifo_full && !pop;
  // Dropped vectors still consume a beat so the job length stays fixed.
  assign last_beat = take && (beat_cnt == num_q - 1'b1);

  sync_fifo #(.W(N*Tn), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (take),
    .pop   (pop),
    .din   (bus.i_data),
    .dout  (bus.o_edram_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (i_start) state_n = (i_num_beats == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (last_beat) state_n = ST_DRAIN;
      ST_DRAIN: if (fifo_empty || ((fifo_count == CW'(1)) && pop)) state_n = ST_DONE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      num_q    <= '0;
      beat_cnt <= '0;
      addr_q   <= '0;
    end else begin
      state <= state_n;
      if (start_ok) begin
        num_q    <= i_num_beats;
        beat_cnt <= '0;
        addr_q   <= i_base_addr;
      end else begin
        if (take) beat_cnt <= beat_cnt + 1'b1;
        // Address follows pops only, so drops leave no gaps in eDRAM.
        if (pop)  addr_q   <= addr_q + 1'b1;
      end
    end
  end

  assign bus.o_edram_valid = !fifo_empty;
  assign bus.o_edram_addr  = addr_q;
  assign o_busy            = (state != ST_IDLE);
  assign o_done            = (state == ST_DONE);

`ifdef NBOUT_WR_STICKY_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rst_n)        err_q <= 1'b0;
    else if (start_ok) err_q <= 1'b0;
    else if (o_drop)   err_q <= 1'b1;
  end
  assign o_err = err_q;
`endif

endmodule

// File: tb/tb_nbout_edram_writer.sv
// Directed bench for nbout_edram_writer; o_err checks follow NBOUT_WR_STICKY_ERR_EN.
module tb_nbout_edram_writer;

  localparam int N = 16, TN = 16, AW = 16, CNT_W = 16, DW = N*TN;

  logic clk = 1'b0;
  logic rst_n;
  logic i_start;
  logic [AW-1:0] i_base_addr;
  logic [CNT_W-1:0] i_num_beats;
  logic o_busy, o_done, o_drop;
`ifdef NBOUT_WR_STICKY_ERR_EN
  logic o_err;
`endif

  always #5 clk = ~clk;

  nbout_edram_writer_if #(.N(N), .Tn(TN), .EDRAM_AW(AW)) bus ();

  nbout_edram_writer #(.N(N), .Tn(TN), .DEPTH(4), .EDRAM_AW(AW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_num_beats (i_num_beats),
    .bus         (bus),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_drop      (o_drop)
`ifdef NBOUT_WR_STICKY_ERR_EN
    ,
    .o_err       (o_err)
`endif
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  logic [DW-1:0] wr_data_q[$];
  logic [AW-1:0] wr_addr_q[$];
  int n_drop, n_done, done_cyc, last_wr_cyc;

  always @(posedge clk) cyc++;

  // Capture write handshakes, drops and done pulses mid-cycle.
  always @(negedge clk) if (rst_n) begin
    if (bus.o_edram_valid && bus.i_edram_ready) begin
      wr_data_q.push_back(bus.o_edram_data);
      wr_addr_q.push_back(bus.o_edram_addr);
      last_wr_cyc = cyc;
    end
    if (o_drop) n_drop++;
    if (o_done) begin
      if (n_done == 0) done_cyc = cyc;
      n_done++;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] vec(input int k);
    logic [15:0] w;
    w = 16'hA000 + 16'(k);
    return {TN{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wr_data_q.delete();
    wr_addr_q.delete();
    n_drop = 0; n_done = 0; done_cyc = -1; last_wr_cyc = -1;
  endtask

  task automatic start(input logic [AW-1:0] base, input logic [CNT_W-1:0] num);
    i_start = 1'b1; i_base_addr = base; i_num_beats = num;
    tick();
    i_start = 1'b0;
  endtask

  task automatic feed(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_valid = 1'b1; bus.i_data = vec(first + i);
      tick();
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_done && n < 60) begin tick(); n++; end
    chk(tag, o_done, 1'b1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_num_beats = '0;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_edram_ready = 1'b0;
    clr();
    repeat (3) tick();
    chk("rst_valid", bus.o_edram_valid, 1'b0);
    chk("rst_data",  bus.o_edram_data, '0);
    chk("rst_addr",  bus.o_edram_addr, '0);
    chk("rst_busy",  o_busy, 1'b0);
    chk("rst_done",  o_done, 1'b0);
    chk("rst_drop",  o_drop, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: three back-to-back vectors, eDRAM always ready
    clr(); bus.i_edram_ready = 1'b1;
    start(16'h0010, 16'd3);
    chk("t1_busy", o_busy, 1'b1);
    feed(0, 3);
    wait_done("t1_done");
    chk("t1_nwr", wr_addr_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("t1_addr", wr_addr_q[k], 16'h0010 + 16'(k));
      chk("t1_data", wr_data_q[k], vec(k));
    end
    chk("t1_done_lat", done_cyc - last_wr_cyc, 1);
    repeat (2) tick();
    chk("t1_done_pulse", n_done, 1);
    chk("t1_idle", o_busy, 1'b0);

    // 2: eDRAM stalled 10 cycles, six vectors, last two dropped
    clr(); bus.i_edram_ready = 1'b0;
    start(16'h0100, 16'd6);
    feed(0, 6);
    repeat (4) tick();
    chk("t2_hold_addr", bus.o_edram_addr, 16'h0100);
    chk("t2_hold_data", bus.o_edram_data, vec(0));
    bus.i_edram_ready = 1'b1;
    wait_done("t2_done");
    chk("t2_drops", n_drop, 2);
    chk("t2_nwr", wr_addr_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_addr", wr_addr_q[k], 16'h0100 + 16'(k));
      chk("t2_data", wr_data_q[k], vec(k));
    end
`ifdef NBOUT_WR_STICKY_ERR_EN
    chk("t2_err_set", o_err, 1'b1);
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    chk("t2_err_rst", o_err, 1'b0);
`endif

    // 3: full FIFO, push and pop in the same cycle
    clr(); bus.i_edram_ready = 1'b0;
    start(16'h0200, 16'd5);
    feed(0, 4);
    chk("t3_full", dut.u_fifo.count, 4);
    bus.i_valid = 1'b1; bus.i_data = vec(4); bus.i_edram_ready = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    chk("t3_count", dut.u_fifo.count, 4);
    chk("t3_head", bus.o_edram_data, vec(1));
    wait_done("t3_done");
    chk("t3_drops", n_drop, 0);
    chk("t3_nwr", wr_addr_q.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk("t3_addr", wr_addr_q[k], 16'h0200 + 16'(k));
      chk("t3_data", wr_data_q[k], vec(k));
    end

    // 4: address wrap
    clr();
    start(16'hFFFF, 16'd2);
    feed(7, 2);
    wait_done("t4_done");
    chk("t4_nwr", wr_addr_q.size(), 2);
    chk("t4_addr0", wr_addr_q[0], 16'hFFFF);
    chk("t4_addr1", wr_addr_q[1], 16'h0000);
    chk("t4_data1", wr_data_q[1], vec(8));

    // 5: empty job, then i_start while running
    clr();
    start(16'h0300, 16'd0);
    chk("t5_done_hi", o_done, 1'b1);
    tick();
    chk("t5_done_lo", o_done, 1'b0);
    chk("t5_idle", o_busy, 1'b0);
    chk("t5_nwr0", wr_addr_q.size(), 0);
    clr();
    start(16'h0300, 16'd2);
    i_start = 1'b1; i_base_addr = 16'h0500; i_num_beats = 16'd9;
    bus.i_valid = 1'b1; bus.i_data = vec(0);
    tick();
    i_start = 1'b0;
    feed(1, 1);
    wait_done("t5_run_done");
    chk("t5_nwr", wr_addr_q.size(), 2);
    chk("t5_addr0", wr_addr_q[0], 16'h0300);
    chk("t5_addr1", wr_addr_q[1], 16'h0301);

    // 6: reset with two entries queued
    clr(); bus.i_edram_ready = 1'b0;
    start(16'h0400, 16'd4);
    feed(0, 2);
    chk("t6_queued", bus.o_edram_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("t6_valid", bus.o_edram_valid, 1'b0);
    chk("t6_busy", o_busy, 1'b0);
    rst_n = 1'b1; bus.i_edram_ready = 1'b1;
    repeat (3) tick();
    chk("t6_valid_after", bus.o_edram_valid, 1'b0);
    chk("t6_nwr", wr_addr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
